// File: rtl/read_addr_hazard_gate_pkg.sv
// Shared types and constants for the read-after-write hazard gate.
// Holds the FSM state encoding, hazard-entry count and address width.
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BANK_BITS
`define BANK_BITS 3
`endif

package read_addr_hazard_gate_pkg;

    localparam int N_HAZ_ENTRIES = 8;
    localparam int DATA_W_DEF = `ROW_BITS + `COL_BITS + `BANK_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_STALL,
        ST_ISSUE
    } state_e;

endpackage

// File: rtl/read_addr_hazard_gate_if.sv
// Read request and backend command handshakes of the hazard gate.
// master: requester/backend side; slave: the gate itself.
interface read_addr_hazard_gate_if
    import read_addr_hazard_gate_pkg::*;
#(
    parameter int DW = DATA_W_DEF
) ();

    logic          i_rd_valid;
    logic          o_rd_ready;
    logic [DW-1:0] i_rd_addr;
    logic          o_cmd_valid;
    logic          i_cmd_ready;
    logic [DW-1:0] o_cmd_addr;

    modport master (
        output i_rd_valid,
        output i_rd_addr,
        output i_cmd_ready,
        input  o_rd_ready,
        input  o_cmd_valid,
        input  o_cmd_addr
    );

    modport slave (
        input  i_rd_valid,
        input  i_rd_addr,
        input  i_cmd_ready,
        output o_rd_ready,
        output o_cmd_valid,
        output o_cmd_addr
    );

endinterface

// File: rtl/read_addr_hazard_gate_raw_match_unit.sv
// Combinational 8-way RAW compare of a read address against pending writes.
// Ports: i_addr, i_entries ({valid,addr} per entry), i_empty, o_hit.
module raw_match_unit
    import read_addr_hazard_gate_pkg::*;
#(
    parameter int DW = DATA_W_DEF
) (
    input  logic [DW-1:0]                   i_addr,
    input  logic [N_HAZ_ENTRIES-1:0][DW:0]  i_entries,
    input  logic                            i_empty,
    output logic                            o_hit
);

    always_comb begin
        o_hit = 1'b0;
        for (int k = 0; k < N_HAZ_ENTRIES; k++) begin
            if (i_entries[k][DW] && (i_entries[k][DW-1:0] == i_addr)) begin
                o_hit = 1'b1;
            end
        end
        // An empty write FIFO means the snapshot is stale: nothing pending.
        if (i_empty) begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/read_addr_hazard_gate.sv
// Holds a read until no pending write targets its address, then issues it.
// Ports: i_clk/i_rst, bus (read req + cmd), write snapshot, stall/drain/count.
`ifndef ROW_BITS
`define ROW_BITS 14
`endif
`ifndef COL_BITS
`define COL_BITS 10
`endif
`ifndef BANK_BITS
`define BANK_BITS 3
`endif

module read_addr_hazard_gate
    import read_addr_hazard_gate_pkg::*;
#(
    parameter int DATA_WIDTH  = `ROW_BITS + `COL_BITS + `BANK_BITS,
    parameter int STALL_LIMIT = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    read_addr_hazard_gate_if.slave bus,
    input  logic [DATA_WIDTH:0]   i_wr_addr_0,
    input  logic [DATA_WIDTH:0]   i_wr_addr_1,
    input  logic [DATA_WIDTH:0]   i_wr_addr_2,
    input  logic [DATA_WIDTH:0]   i_wr_addr_3,
    input  logic [DATA_WIDTH:0]   i_wr_addr_4,
    input  logic [DATA_WIDTH:0]   i_wr_addr_5,
    input  logic [DATA_WIDTH:0]   i_wr_addr_6,
    input  logic [DATA_WIDTH:0]   i_wr_addr_7,
    input  logic                  i_wfifo_empty,
    output logic                  o_stall,
    output logic                  o_drain_req,
    output logic [15:0]           o_hazard_cnt
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   addr_q, addr_d;
    logic [CW-1:0]           stall_cnt_q, stall_cnt_d;
    logic [15:0]             hazard_cnt_q, hazard_cnt_d;
    logic                    rd_ready_q, rd_ready_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    stall_q, stall_d;
    logic                    drain_q, drain_d;

    logic [N_HAZ_ENTRIES-1:0][DATA_WIDTH:0] entries;
    logic                                   hit;

    assign entries = {i_wr_addr_7, i_wr_addr_6, i_wr_addr_5, i_wr_addr_4,
                      i_wr_addr_3, i_wr_addr_2, i_wr_addr_1, i_wr_addr_0};

    raw_match_unit #(
        .DW(DATA_WIDTH)
    ) u_match (
        .i_addr   (addr_q),
        .i_entries(entries),
        .i_empty  (i_wfifo_empty),
        .o_hit    (hit)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stall_cnt_d  = stall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_rd_valid) begin
                    addr_d  = bus.i_rd_addr;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    state_d = ST_STALL;
                    // Counter tracks STALL cycles spent, current one included.
                    stall_cnt_d = CW'(1);
                    if (hazard_cnt_q != 16'hFFFF) begin
                        hazard_cnt_d = hazard_cnt_q + 16'd1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_STALL: begin
                if (!hit) begin
                    state_d = ST_ISSUE;
                end else if (stall_cnt_q != LIMIT) begin
                    stall_cnt_d = stall_cnt_q + CW'(1);
                end
            end
            ST_ISSUE: begin
                if (bus.i_cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state.
        rd_ready_d  = (state_d == ST_IDLE);
        cmd_valid_d = (state_d == ST_ISSUE);
        stall_d     = (state_d == ST_STALL);
        drain_d     = (state_d == ST_STALL) && (stall_cnt_d == LIMIT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
            rd_ready_q   <= 1'b1;
            cmd_valid_q  <= 1'b0;
            stall_q      <= 1'b0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stall_cnt_q  <= stall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
            rd_ready_q   <= rd_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            stall_q      <= stall_d;
            drain_q      <= drain_d;
        end
    end

    assign bus.o_rd_ready  = rd_ready_q;
    assign bus.o_cmd_valid = cmd_valid_q;
    assign bus.o_cmd_addr  = addr_q;
    assign o_stall         = stall_q;
    assign o_drain_req     = drain_q;
    assign o_hazard_cnt    = hazard_cnt_q;

endmodule
